alu_reservation_station: RTL and testbench
==========================================

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter RS_SIZE, default 8, number of entries (power of two, 2..16).
REQ-002 Parameter CSU_SIZE_BITS, default 4, width of instruction ids and dependency tags.
REQ-003 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 rdy_in  input  1  ready; when low, all state and outputs hold.
REQ-006 flush_pipline  input  1  discard all entries.
REQ-007 dispatch_valid  input  1  new instruction offered this cycle.
REQ-008 dispatch_ins_id  input  CSU_SIZE_BITS  id of offered instruction.
REQ-009 dispatch_opcode/funct3/funct7  input  7/3/7  decoded fields.
REQ-010 dispatch_imm, dispatch_pc  input  32 each  immediate, instruction PC.
REQ-011 dispatch_shamt  input  6  shift amount.
REQ-012 dispatch_is_compressed  input  1  16-bit instruction flag.
REQ-013 dispatch_rs1_rdy, dispatch_rs2_rdy  input  1 each  operand already valid.
REQ-014 dispatch_rs1_val, dispatch_rs2_val  input  32 each  operand value when ready.
REQ-015 dispatch_rs1_tag, dispatch_rs2_tag  input  CSU_SIZE_BITS each  producer id when not ready.
REQ-016 cdb_alu_rdy, cdb_alu_id, cdb_alu_res  input  1/CSU_SIZE_BITS/32  ALU result broadcast.
REQ-017 cdb_mem_rdy, cdb_mem_id, cdb_mem_res  input  1/CSU_SIZE_BITS/32  load-unit result broadcast.
REQ-018 rs_full  output  1  no free entry; dispatch not accepted.
REQ-019 have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val, opcode, funct3, funct7, request_PC, is_compressed_ins  output  matching ALU input widths  registered issue bundle.

Function
REQ-020 Dispatch accepted at a rising edge iff dispatch_valid=1, rs_full=0, flush_pipline=0, rdy_in=1, rst_in=1; written into the lowest-index free entry.
REQ-021 rs_full SHALL be 1 exactly when all RS_SIZE entries are valid, evaluated from registered state (before same-cycle issue frees an entry).
REQ-022 Each entry operand not ready SHALL capture the value of any CDB bus with rdy=1 and id equal to its tag, and become ready the same edge.
REQ-023 Dispatch-cycle bypass: a not-ready dispatched operand whose tag matches an active CDB bus in that same cycle SHALL be stored ready with the CDB value.
REQ-024 If both CDB buses match one tag, cdb_alu_res takes priority.
REQ-025 Issue: each enabled cycle, the lowest-index valid entry with both operands ready (registered state) SHALL be copied to the issue registers, have_ins<=1, entry freed; otherwise have_ins<=0.
REQ-026 Latency: an entry dispatched with both operands ready issues at the earliest one edge after dispatch; an operand woken by CDB at edge N allows issue at edge N+1.
REQ-027 At most one dispatch and one issue per cycle; both may occur in the same cycle, including into the just-freed slot only on the following cycle.
REQ-028 Issue bundle fields SHALL hold their last values when have_ins=0.
REQ-029 flush_pipline=1 (rdy_in=1) SHALL clear all entry valid bits and have_ins<=0 at that edge; concurrent dispatch and CDB are ignored.
REQ-030 rdy_in=0 SHALL freeze entries, outputs and CDB capture; CDB events during the stall are lost (producer holds them).

Reset
REQ-031 rst_in=0 at a rising edge SHALL clear all valid bits, have_ins=0, rs_full=0, and all issue bundle fields to 0, overriding rdy_in and flush.
REQ-032 Reset mid-operation discards all pending entries without issue.

Structure
REQ-033 Shared package holds CSU_SIZE_BITS, RS_SIZE default, and opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, OP_IMM, OP).
REQ-034 One sub-module, rs_issue_select: combinational lowest-index picker over RS_SIZE ready bits returning found flag and index; free-slot search reuses it.

Verification
REQ-035 Reset: rst_in=0 two cycles -> have_ins=0, rs_full=0, ins_id=0.
REQ-036 Ready ADDI id=3, rs1=5, imm=7 -> next edge have_ins=1, ins_id=3, rs1_val=5, imm_val=7; following edge have_ins=0.
REQ-037 ADD id=2 with rs2 tag=1 not ready; cdb_alu_rdy=1, id=1, res=0x10 two cycles later -> issue one edge after broadcast with rs2_val=0x10.
REQ-038 Bypass: dispatch with rs1 tag=6 while cdb_mem id=6 res=0xAB -> issues next edge, rs1_val=0xAB.
REQ-039 Fill 8 non-ready entries -> rs_full=1, 9th dispatch rejected; wake entry 4 -> issues, rs_full=0 next cycle, retried dispatch accepted.
REQ-040 5 entries pending, flush_pipline=1 -> have_ins=0, rs_full=0, no later issue of flushed ids even after matching CDB broadcasts.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared constants for the ALU reservation station slice.
// Holds default sizes and the RV32 opcodes handled by the ALU.
package alu_reservation_station_pkg;

    localparam int CSU_SIZE_BITS_DEF = 4;
    localparam int RS_SIZE_DEF       = 8;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/rs_issue_select.sv
// Lowest-index picker over a request vector.
// Ports: i_req (request bits), o_found (any set), o_idx (lowest set index).
module rs_issue_select #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops, wakes operands from
// two CDB buses, issues the lowest ready entry into a registered bundle.
// Ports: clk_in/rst_in/rdy_in/flush_pipline control, dispatch_* inputs,
// cdb_alu_*/cdb_mem_* broadcasts, rs_full, and the issue bundle outputs.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE       = RS_SIZE_DEF,
    parameter int CSU_SIZE_BITS = CSU_SIZE_BITS_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_pipline,
    input  logic                     dispatch_valid,
    input  logic [CSU_SIZE_BITS-1:0] dispatch_ins_id,
    input  logic [6:0]               dispatch_opcode,
    input  logic [2:0]               dispatch_funct3,
    input  logic [6:0]               dispatch_funct7,
    input  logic [31:0]              dispatch_imm,
    input  logic [31:0]              dispatch_pc,
    input  logic [5:0]               dispatch_shamt,
    input  logic                     dispatch_is_compressed,
    input  logic                     dispatch_rs1_rdy,
    input  logic                     dispatch_rs2_rdy,
    input  logic [31:0]              dispatch_rs1_val,
    input  logic [31:0]              dispatch_rs2_val,
    input  logic [CSU_SIZE_BITS-1:0] dispatch_rs1_tag,
    input  logic [CSU_SIZE_BITS-1:0] dispatch_rs2_tag,
    input  logic                     cdb_alu_rdy,
    input  logic [CSU_SIZE_BITS-1:0] cdb_alu_id,
    input  logic [31:0]              cdb_alu_res,
    input  logic                     cdb_mem_rdy,
    input  logic [CSU_SIZE_BITS-1:0] cdb_mem_id,
    input  logic [31:0]              cdb_mem_res,
    output logic                     rs_full,
    output logic                     have_ins,
    output logic [CSU_SIZE_BITS-1:0] ins_id,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,
    output logic [31:0]              imm_val,
    output logic [5:0]               shamt_val,
    output logic [6:0]               opcode,
    output logic [2:0]               funct3,
    output logic [6:0]               funct7,
    output logic [31:0]              request_PC,
    output logic                     is_compressed_ins
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int TW    = CSU_SIZE_BITS;

    logic [RS_SIZE-1:0] r_valid;
    logic [RS_SIZE-1:0] r_rs1_rdy;
    logic [RS_SIZE-1:0] r_rs2_rdy;
    logic [TW-1:0]      r_id     [RS_SIZE];
    logic [TW-1:0]      r_rs1_tag[RS_SIZE];
    logic [TW-1:0]      r_rs2_tag[RS_SIZE];
    logic [31:0]        r_rs1_v  [RS_SIZE];
    logic [31:0]        r_rs2_v  [RS_SIZE];
    logic [31:0]        r_imm    [RS_SIZE];
    logic [31:0]        r_pc     [RS_SIZE];
    logic [5:0]         r_shamt  [RS_SIZE];
    logic [6:0]         r_opc    [RS_SIZE];
    logic [2:0]         r_f3     [RS_SIZE];
    logic [6:0]         r_f7     [RS_SIZE];
    logic [RS_SIZE-1:0] r_cmp;

    logic               r_have;
    logic [TW-1:0]      r_o_id;
    logic [31:0]        r_o_rs1;
    logic [31:0]        r_o_rs2;
    logic [31:0]        r_o_imm;
    logic [5:0]         r_o_shamt;
    logic [6:0]         r_o_opc;
    logic [2:0]         r_o_f3;
    logic [6:0]         r_o_f7;
    logic [31:0]        r_o_pc;
    logic               r_o_cmp;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_iss_found;
    logic [IDX_W-1:0]   w_iss_idx;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_disp_ok;
    logic [32:0]        w_d1;
    logic [32:0]        w_d2;
    logic [32:0]        w_w1 [RS_SIZE];
    logic [32:0]        w_w2 [RS_SIZE];

    // {hit, value}; the ALU bus wins when both buses carry the tag.
    function automatic logic [32:0] cdb_fwd(input logic [TW-1:0] tag);
        if (cdb_alu_rdy && cdb_alu_id == tag)
            return {1'b1, cdb_alu_res};
        else if (cdb_mem_rdy && cdb_mem_id == tag)
            return {1'b1, cdb_mem_res};
        else
            return '0;
    endfunction

    assign w_ready = r_valid & r_rs1_rdy & r_rs2_rdy;
    assign rs_full = &r_valid;

    rs_issue_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_iss_sel (
        .i_req   (w_ready),
        .o_found (w_iss_found),
        .o_idx   (w_iss_idx)
    );

    // Free-slot search; uses registered valid so a slot freed by issue
    // only becomes reusable on the following cycle.
    rs_issue_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
        .i_req   (~r_valid),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    assign w_disp_ok = dispatch_valid && w_free_found && !flush_pipline;

    always_comb begin
        w_d1 = cdb_fwd(dispatch_rs1_tag);
        w_d2 = cdb_fwd(dispatch_rs2_tag);
        for (int i = 0; i < RS_SIZE; i++) begin
            w_w1[i] = cdb_fwd(r_rs1_tag[i]);
            w_w2[i] = cdb_fwd(r_rs2_tag[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_valid   <= '0;
            r_have    <= 1'b0;
            r_o_id    <= '0;
            r_o_rs1   <= '0;
            r_o_rs2   <= '0;
            r_o_imm   <= '0;
            r_o_shamt <= '0;
            r_o_opc   <= '0;
            r_o_f3    <= '0;
            r_o_f7    <= '0;
            r_o_pc    <= '0;
            r_o_cmp   <= 1'b0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                r_valid <= '0;
                r_have  <= 1'b0;
            end else begin
                r_have <= w_iss_found;
                if (w_iss_found) begin
                    r_valid[w_iss_idx] <= 1'b0;
                    r_o_id    <= r_id[w_iss_idx];
                    r_o_rs1   <= r_rs1_v[w_iss_idx];
                    r_o_rs2   <= r_rs2_v[w_iss_idx];
                    r_o_imm   <= r_imm[w_iss_idx];
                    r_o_shamt <= r_shamt[w_iss_idx];
                    r_o_opc   <= r_opc[w_iss_idx];
                    r_o_f3    <= r_f3[w_iss_idx];
                    r_o_f7    <= r_f7[w_iss_idx];
                    r_o_pc    <= r_pc[w_iss_idx];
                    r_o_cmp   <= r_cmp[w_iss_idx];
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_valid[i] && !r_rs1_rdy[i] && w_w1[i][32]) begin
                        r_rs1_rdy[i] <= 1'b1;
                        r_rs1_v[i]   <= w_w1[i][31:0];
                    end
                    if (r_valid[i] && !r_rs2_rdy[i] && w_w2[i][32]) begin
                        r_rs2_rdy[i] <= 1'b1;
                        r_rs2_v[i]   <= w_w2[i][31:0];
                    end
                end
                if (w_disp_ok) begin
                    r_valid[w_free_idx]   <= 1'b1;
                    r_id[w_free_idx]      <= dispatch_ins_id;
                    r_opc[w_free_idx]     <= dispatch_opcode;
                    r_f3[w_free_idx]      <= dispatch_funct3;
                    r_f7[w_free_idx]      <= dispatch_funct7;
                    r_imm[w_free_idx]     <= dispatch_imm;
                    r_pc[w_free_idx]      <= dispatch_pc;
                    r_shamt[w_free_idx]   <= dispatch_shamt;
                    r_cmp[w_free_idx]     <= dispatch_is_compressed;
                    r_rs1_tag[w_free_idx] <= dispatch_rs1_tag;
                    r_rs2_tag[w_free_idx] <= dispatch_rs2_tag;
                    r_rs1_rdy[w_free_idx] <= dispatch_rs1_rdy | w_d1[32];
                    r_rs2_rdy[w_free_idx] <= dispatch_rs2_rdy | w_d2[32];
                    r_rs1_v[w_free_idx]   <= dispatch_rs1_rdy ?
                                             dispatch_rs1_val : w_d1[31:0];
                    r_rs2_v[w_free_idx]   <= dispatch_rs2_rdy ?
                                             dispatch_rs2_val : w_d2[31:0];
                end
            end
        end
    end

    assign have_ins          = r_have;
    assign ins_id            = r_o_id;
    assign rs1_val           = r_o_rs1;
    assign rs2_val           = r_o_rs2;
    assign imm_val           = r_o_imm;
    assign shamt_val         = r_o_shamt;
    assign opcode            = r_o_opc;
    assign funct3            = r_o_f3;
    assign funct7            = r_o_f7;
    assign request_PC        = r_o_pc;
    assign is_compressed_ins = r_o_cmp;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station.
// Drives vectors after each edge and checks outputs #1 past the edge.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_pipline = 1'b0;
    logic        dispatch_valid = 1'b0;
    logic [3:0]  dispatch_ins_id = '0;
    logic [6:0]  dispatch_opcode = '0;
    logic [2:0]  dispatch_funct3 = '0;
    logic [6:0]  dispatch_funct7 = '0;
    logic [31:0] dispatch_imm = '0;
    logic [31:0] dispatch_pc = '0;
    logic [5:0]  dispatch_shamt = '0;
    logic        dispatch_is_compressed = 1'b0;
    logic        dispatch_rs1_rdy = 1'b0;
    logic        dispatch_rs2_rdy = 1'b0;
    logic [31:0] dispatch_rs1_val = '0;
    logic [31:0] dispatch_rs2_val = '0;
    logic [3:0]  dispatch_rs1_tag = '0;
    logic [3:0]  dispatch_rs2_tag = '0;
    logic        cdb_alu_rdy = 1'b0;
    logic [3:0]  cdb_alu_id = '0;
    logic [31:0] cdb_alu_res = '0;
    logic        cdb_mem_rdy = 1'b0;
    logic [3:0]  cdb_mem_id = '0;
    logic [31:0] cdb_mem_res = '0;
    logic        rs_full;
    logic        have_ins;
    logic [3:0]  ins_id;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_val;
    logic [5:0]  shamt_val;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] request_PC;
    logic        is_compressed_ins;

    int n_vec = 0;
    int n_err = 0;

    alu_reservation_station dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .flush_pipline          (flush_pipline),
        .dispatch_valid         (dispatch_valid),
        .dispatch_ins_id        (dispatch_ins_id),
        .dispatch_opcode        (dispatch_opcode),
        .dispatch_funct3        (dispatch_funct3),
        .dispatch_funct7        (dispatch_funct7),
        .dispatch_imm           (dispatch_imm),
        .dispatch_pc            (dispatch_pc),
        .dispatch_shamt         (dispatch_shamt),
        .dispatch_is_compressed (dispatch_is_compressed),
        .dispatch_rs1_rdy       (dispatch_rs1_rdy),
        .dispatch_rs2_rdy       (dispatch_rs2_rdy),
        .dispatch_rs1_val       (dispatch_rs1_val),
        .dispatch_rs2_val       (dispatch_rs2_val),
        .dispatch_rs1_tag       (dispatch_rs1_tag),
        .dispatch_rs2_tag       (dispatch_rs2_tag),
        .cdb_alu_rdy            (cdb_alu_rdy),
        .cdb_alu_id             (cdb_alu_id),
        .cdb_alu_res            (cdb_alu_res),
        .cdb_mem_rdy            (cdb_mem_rdy),
        .cdb_mem_id             (cdb_mem_id),
        .cdb_mem_res            (cdb_mem_res),
        .rs_full                (rs_full),
        .have_ins               (have_ins),
        .ins_id                 (ins_id),
        .rs1_val                (rs1_val),
        .rs2_val                (rs2_val),
        .imm_val                (imm_val),
        .shamt_val              (shamt_val),
        .opcode                 (opcode),
        .funct3                 (funct3),
        .funct7                 (funct7),
        .request_PC             (request_PC),
        .is_compressed_ins      (is_compressed_ins)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [3:0] id, input logic [6:0] opc,
                        input logic r1, input logic [31:0] v1,
                        input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2,
                        input logic [3:0] t2, input logic [31:0] imm);
        dispatch_valid   = 1'b1;
        dispatch_ins_id  = id;
        dispatch_opcode  = opc;
        dispatch_rs1_rdy = r1;
        dispatch_rs1_val = v1;
        dispatch_rs1_tag = t1;
        dispatch_rs2_rdy = r2;
        dispatch_rs2_val = v2;
        dispatch_rs2_tag = t2;
        dispatch_imm     = imm;
    endtask

    task automatic cdb_clr();
        cdb_alu_rdy = 1'b0;
        cdb_mem_rdy = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_have", 32'(have_ins), 32'd0);
        chk("rst_full", 32'(rs_full), 32'd0);
        chk("rst_id", 32'(ins_id), 32'd0);
        chk("rst_rs1", rs1_val, 32'd0);
        rst_in = 1'b1;

        // Ready ADDI
        disp(4'd3, OPC_OP_IMM, 1'b1, 32'd5, 4'd0,
             1'b1, 32'd0, 4'd0, 32'd7);
        tick();
        dispatch_valid = 1'b0;
        chk("addi_lat", 32'(have_ins), 32'd0);
        tick();
        chk("addi_have", 32'(have_ins), 32'd1);
        chk("addi_id", 32'(ins_id), 32'd3);
        chk("addi_rs1", rs1_val, 32'd5);
        chk("addi_imm", imm_val, 32'd7);
        chk("addi_opc", 32'(opcode), 32'(OPC_OP_IMM));
        tick();
        chk("addi_drop", 32'(have_ins), 32'd0);
        chk("addi_hold", 32'(ins_id), 32'd3);

        // ADD waiting on tag 1
        disp(4'd2, OPC_OP, 1'b1, 32'd1, 4'd0,
             1'b0, 32'd0, 4'd1, 32'd0);
        tick();
        dispatch_valid = 1'b0;
        tick();
        chk("add_wait", 32'(have_ins), 32'd0);
        cdb_alu_rdy = 1'b1;
        cdb_alu_id  = 4'd1;
        cdb_alu_res = 32'h10;
        tick();
        cdb_clr();
        chk("add_wake", 32'(have_ins), 32'd0);
        tick();
        chk("add_have", 32'(have_ins), 32'd1);
        chk("add_id", 32'(ins_id), 32'd2);
        chk("add_rs2", rs2_val, 32'h10);

        // Dispatch-cycle bypass from mem bus
        disp(4'd5, OPC_OP, 1'b0, 32'd0, 4'd6,
             1'b1, 32'd0, 4'd0, 32'd0);
        cdb_mem_rdy = 1'b1;
        cdb_mem_id  = 4'd6;
        cdb_mem_res = 32'hAB;
        tick();
        dispatch_valid = 1'b0;
        cdb_clr();
        tick();
        chk("byp_have", 32'(have_ins), 32'd1);
        chk("byp_id", 32'(ins_id), 32'd5);
        chk("byp_rs1", rs1_val, 32'hAB);

        // Fill all eight entries with ops waiting on tags 8..15
        for (int k = 0; k < 8; k++) begin
            disp(4'(k), OPC_OP, 1'b0, 32'd0, 4'(8 + k),
                 1'b1, 32'd0, 4'd0, 32'd0);
            tick();
        end
        chk("fill_full", 32'(rs_full), 32'd1);
        disp(4'd9, OPC_OP_IMM, 1'b1, 32'h99, 4'd0,
             1'b1, 32'd0, 4'd0, 32'd0);
        tick();
        chk("rej_full", 32'(rs_full), 32'd1);
        chk("rej_have", 32'(have_ins), 32'd0);
        cdb_alu_rdy = 1'b1;
        cdb_alu_id  = 4'd12;
        cdb_alu_res = 32'h44;
        tick();
        cdb_clr();
        chk("wake4_full", 32'(rs_full), 32'd1);
        tick();
        chk("iss4_have", 32'(have_ins), 32'd1);
        chk("iss4_id", 32'(ins_id), 32'd4);
        chk("iss4_rs1", rs1_val, 32'h44);
        chk("iss4_full", 32'(rs_full), 32'd0);
        tick();
        dispatch_valid = 1'b0;
        chk("retry_full", 32'(rs_full), 32'd1);
        tick();
        chk("retry_have", 32'(have_ins), 32'd1);
        chk("retry_id", 32'(ins_id), 32'd9);
        chk("retry_rs1", rs1_val, 32'h99);

        // Mid-operation reset drops the seven pending entries
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        chk("mrst_have", 32'(have_ins), 32'd0);
        chk("mrst_full", 32'(rs_full), 32'd0);
        chk("mrst_id", 32'(ins_id), 32'd0);

        // Five pending entries then flush
        for (int k = 0; k < 5; k++) begin
            disp(4'(k), OPC_OP, 1'b0, 32'd0, 4'(8 + k),
                 1'b1, 32'd0, 4'd0, 32'd0);
            tick();
        end
        flush_pipline = 1'b1;
        disp(4'd13, OPC_OP_IMM, 1'b1, 32'd1, 4'd0,
             1'b1, 32'd0, 4'd0, 32'd0);
        cdb_alu_rdy = 1'b1;
        cdb_alu_id  = 4'd8;
        cdb_alu_res = 32'h1;
        tick();
        flush_pipline  = 1'b0;
        dispatch_valid = 1'b0;
        chk("fl_have", 32'(have_ins), 32'd0);
        chk("fl_full", 32'(rs_full), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cdb_alu_id = 4'(8 + k);
            tick();
            chk("fl_quiet", 32'(have_ins), 32'd0);
        end
        cdb_clr();
        tick();
        chk("fl_after", 32'(have_ins), 32'd0);

        // Stall freezes issue and holds outputs
        disp(4'd7, OPC_OP_IMM, 1'b1, 32'h77, 4'd0,
             1'b1, 32'd0, 4'd0, 32'd0);
        tick();
        dispatch_valid = 1'b0;
        rdy_in = 1'b0;
        tick();
        chk("stall_no_iss", 32'(have_ins), 32'd0);
        rdy_in = 1'b1;
        tick();
        chk("stall_iss", 32'(have_ins), 32'd1);
        chk("stall_id", 32'(ins_id), 32'd7);
        rdy_in = 1'b0;
        tick();
        chk("stall_hold", 32'(have_ins), 32'd1);
        rdy_in = 1'b1;
        tick();
        chk("stall_drop", 32'(have_ins), 32'd0);

        // Both buses carry the same tag: ALU result wins
        disp(4'd6, OPC_OP, 1'b0, 32'd0, 4'd3,
             1'b1, 32'd0, 4'd0, 32'd0);
        tick();
        dispatch_valid = 1'b0;
        cdb_alu_rdy = 1'b1;
        cdb_alu_id  = 4'd3;
        cdb_alu_res = 32'h11;
        cdb_mem_rdy = 1'b1;
        cdb_mem_id  = 4'd3;
        cdb_mem_res = 32'h22;
        tick();
        cdb_clr();
        tick();
        chk("prio_have", 32'(have_ins), 32'd1);
        chk("prio_id", 32'(ins_id), 32'd6);
        chk("prio_rs1", rs1_val, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
